telemetry_sync_fifo: RTL and testbench

Single-clock, parametrised FIFO that replaces the fixed 32×1024 dual-clock FIFO core on paths where producer and consumer share one clock. It sits between the Rice-decoder output packer and the downstream telemetry sink. It adds the following over the fixed core:
- generic width and depth;
- a selectable first-word-fall-through (FWFT) read mode;
- programmable full and empty thresholds;
- sticky-free overflow and underflow pulses.

---
 rtl/telemetry_sync_fifo.sv | 136 +++++++++++++
 tb/tb_telemetry_sync_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_sync_fifo.sv
// rtl/telemetry_sync_fifo.sv - single-clock parametrised FIFO with optional FWFT read mode
module telemetry_sync_fifo #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 10,
    parameter int FWFT          = 0,
    parameter int PROG_FULL_TH  = 1000,
    parameter int PROG_EMPTY_TH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              prog_full,
    output logic              prog_empty,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow,
    output logic              rst_busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PF_TH     = (ADDR_W+1)'(PROG_FULL_TH);
    localparam logic [ADDR_W:0]   PE_TH     = (ADDR_W+1)'(PROG_EMPTY_TH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam bit                FWFT_MODE = (FWFT != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic [ADDR_W:0]   ram_cnt_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic [1:0]        busy_cnt;
    logic              busy_nxt;
    logic              valid_r;
    logic              wr_acc;
    logic              rd_acc;
    logic              ram_rd;
    logic              empty_nxt;

    always_comb begin
        wr_acc = wr_en & ~full & ~rst_busy & ~rst;
        rd_acc = rd_en & ~empty & ~rst_busy & ~rst;

        // In FWFT the RAM is read to prefetch into an empty output register or to refill it on a pop.
        if (FWFT_MODE) begin
            ram_rd = (ram_cnt != '0) & (empty | rd_acc) & ~rst;
        end else begin
            ram_rd = rd_acc;
        end

        count_nxt = data_count;
        if (wr_acc & ~rd_acc) begin
            count_nxt = data_count + CNT_ONE;
        end else if (rd_acc & ~wr_acc) begin
            count_nxt = data_count - CNT_ONE;
        end

        ram_cnt_nxt = ram_cnt;
        if (wr_acc & ~ram_rd) begin
            ram_cnt_nxt = ram_cnt + CNT_ONE;
        end else if (ram_rd & ~wr_acc) begin
            ram_cnt_nxt = ram_cnt - CNT_ONE;
        end

        if (FWFT_MODE) begin
            empty_nxt = empty;
            if (ram_rd) begin
                empty_nxt = 1'b0;
            end else if (rd_acc) begin
                empty_nxt = 1'b1;
            end
        end else begin
            empty_nxt = (count_nxt == '0);
        end

        busy_nxt = (busy_cnt != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            data_count <= '0;
            busy_cnt   <= 2'd2;
            rst_busy   <= 1'b1;
            full       <= 1'b1;
            empty      <= 1'b1;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            valid_r    <= 1'b0;
            dout       <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr];
            end
            ram_cnt    <= ram_cnt_nxt;
            data_count <= count_nxt;
            if (busy_cnt != 2'd0) begin
                busy_cnt <= busy_cnt - 2'd1;
            end
            rst_busy   <= busy_nxt;
            // full is held high through the busy window so nothing can be written early.
            full       <= busy_nxt | (count_nxt == DEPTH_C);
            empty      <= empty_nxt;
            prog_full  <= (count_nxt >= PF_TH);
            prog_empty <= (count_nxt <= PE_TH);
            overflow   <= wr_en & ~rst_busy & ~wr_acc;
            underflow  <= rd_en & ~rst_busy & ~rd_acc;
            valid_r    <= rd_acc & ~FWFT_MODE;
        end
    end

    assign valid = FWFT_MODE ? ~empty : valid_r;

endmodule

// File: tb/tb_telemetry_sync_fifo.sv
// tb/tb_telemetry_sync_fifo.sv - self-checking bench for telemetry_sync_fifo (standard and FWFT)
`timescale 1ns/1ps
module tb_telemetry_sync_fifo;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int PF    = 1000;
    localparam int PE    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] s_din, f_din;
    logic          s_wr_en, s_rd_en, f_wr_en, f_rd_en;
    logic [DW-1:0] s_dout, f_dout;
    logic          s_valid, s_full, s_empty, s_prog_full, s_prog_empty, s_overflow, s_underflow, s_rst_busy;
    logic          f_valid, f_full, f_empty, f_prog_full, f_prog_empty, f_overflow, f_underflow, f_rst_busy;
    logic [AW:0]   s_data_count, f_data_count;

    telemetry_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0), .PROG_FULL_TH(PF), .PROG_EMPTY_TH(PE)) u_std (
        .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr_en), .rd_en(s_rd_en), .dout(s_dout),
        .valid(s_valid), .full(s_full), .empty(s_empty), .prog_full(s_prog_full),
        .prog_empty(s_prog_empty), .data_count(s_data_count), .overflow(s_overflow),
        .underflow(s_underflow), .rst_busy(s_rst_busy)
    );

    telemetry_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1), .PROG_FULL_TH(PF), .PROG_EMPTY_TH(PE)) u_fwft (
        .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en), .dout(f_dout),
        .valid(f_valid), .full(f_full), .empty(f_empty), .prog_full(f_prog_full),
        .prog_empty(f_prog_empty), .data_count(f_data_count), .overflow(f_overflow),
        .underflow(f_underflow), .rst_busy(f_rst_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Standard-mode reference: a plain queue of stored words plus the last word handed out.
    logic [DW-1:0] sq[$];
    logic [DW-1:0] s_exp_dout;
    bit            s_exp_valid, s_exp_ovf, s_exp_udf;

    // FWFT reference: each word remembers the edge it was written; the head is visible one edge later.
    logic [DW-1:0] fq[$];
    int            fe[$];
    int            f_edge;
    bit            f_exp_empty, f_exp_ovf, f_exp_udf;

    task automatic s_step(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit wacc, racc;
        wacc = wr && (sq.size() < DEPTH);
        racc = rd && (sq.size() > 0);
        s_wr_en = wr; s_rd_en = rd; s_din = d;
        @(posedge clk); #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        s_exp_valid = racc;
        s_exp_ovf   = wr && !wacc;
        s_exp_udf   = rd && !racc;
        if (racc) s_exp_dout = sq.pop_front();
        if (wacc) sq.push_back(d);
    endtask

    task automatic f_step(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit wacc, racc;
        wacc = wr && (fq.size() < DEPTH);
        racc = rd && !f_exp_empty;
        f_wr_en = wr; f_rd_en = rd; f_din = d;
        @(posedge clk); #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
        f_edge++;
        if (racc) begin void'(fq.pop_front()); void'(fe.pop_front()); end
        if (wacc) begin fq.push_back(d); fe.push_back(f_edge); end
        f_exp_empty = (fq.size() == 0) || (fe[0] == f_edge);
        f_exp_ovf   = wr && !wacc;
        f_exp_udf   = rd && !racc;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_wr_en = 1'b1; f_wr_en = 1'b1; s_rd_en = 1'b0; f_rd_en = 1'b0;
        s_din = 32'h1234; f_din = 32'h5678;
        @(posedge clk); #1;
        n_total++;
        if ({s_full, s_empty, s_prog_empty, s_prog_full, s_valid, s_overflow, s_underflow, s_rst_busy} !== 8'b1110_0001)
            $display("FAIL reset_flags_std: got %b expected 11100001",
                     {s_full, s_empty, s_prog_empty, s_prog_full, s_valid, s_overflow, s_underflow, s_rst_busy});
        else n_pass++;
        n_total++;
        if ({f_full, f_empty, f_prog_empty, f_prog_full, f_valid, f_overflow, f_underflow, f_rst_busy} !== 8'b1110_0001)
            $display("FAIL reset_flags_fwft: got %b expected 11100001",
                     {f_full, f_empty, f_prog_empty, f_prog_full, f_valid, f_overflow, f_underflow, f_rst_busy});
        else n_pass++;
        n_total++;
        if (s_data_count !== '0 || s_dout !== '0)
            $display("FAIL reset_count_dout: got count %0d dout %h expected 0 0", s_data_count, s_dout);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (s_rst_busy !== (i < 3) || s_full !== (i < 3) || f_rst_busy !== (i < 3))
                $display("FAIL busy_edge%0d: got busy %b full %b fbusy %b expected %b", i, s_rst_busy, s_full, f_rst_busy, (i < 3));
            else n_pass++;
            n_total++;
            if (s_data_count !== '0 || s_overflow !== 1'b0 || f_data_count !== '0 || f_overflow !== 1'b0)
                $display("FAIL busy_ignore%0d: got count %0d ovf %b fcount %0d fovf %b expected 0", i,
                         s_data_count, s_overflow, f_data_count, f_overflow);
            else n_pass++;
        end
        s_wr_en = 1'b0; f_wr_en = 1'b0;
        n_total++;
        if (s_empty !== 1'b1 || f_empty !== 1'b1)
            $display("FAIL post_reset_empty: got %b %b expected 1 1", s_empty, f_empty);
        else n_pass++;
        sq.delete(); s_exp_dout = '0;
        fq.delete(); fe.delete(); f_edge = 0; f_exp_empty = 1'b1;
    endtask

    task automatic test_fill();
        logic [AW:0] ec;
        for (int i = 1; i <= DEPTH; i++) begin
            s_step(1'b1, 1'b0, DW'(i));
            ec = (AW+1)'(sq.size());
            n_total++;
            if ({s_data_count, s_full, s_empty, s_prog_full, s_prog_empty} !==
                {ec, ec == DEPTH, ec == 0, ec >= PF, ec <= PE})
                $display("FAIL fill_%0d: got count %0d flags %b%b%b%b", i, s_data_count,
                         s_full, s_empty, s_prog_full, s_prog_empty);
            else n_pass++;
        end
        s_step(1'b1, 1'b0, 32'h401);
        n_total++;
        if (s_overflow !== 1'b1 || s_data_count !== 11'd1024)
            $display("FAIL overflow_pulse: got ovf %b count %0d expected 1 1024", s_overflow, s_data_count);
        else n_pass++;
        s_step(1'b0, 1'b0, '0);
        n_total++;
        if (s_overflow !== 1'b0 || s_full !== 1'b1 || s_data_count !== 11'd1024)
            $display("FAIL overflow_one_cycle: got ovf %b full %b count %0d expected 0 1 1024",
                     s_overflow, s_full, s_data_count);
        else n_pass++;
    endtask

    task automatic test_full_simul();
        s_step(1'b1, 1'b1, 32'hDEADBEEF);
        n_total++;
        if ({s_overflow, s_full, s_valid} !== 3'b101 || s_data_count !== 11'd1023)
            $display("FAIL full_simul: got ovf %b full %b valid %b count %0d expected 1 0 1 1023",
                     s_overflow, s_full, s_valid, s_data_count);
        else n_pass++;
        n_total++;
        if (s_dout !== 32'h1)
            $display("FAIL full_simul_dout: got %h expected 00000001", s_dout);
        else n_pass++;
    endtask

    task automatic test_drain();
        int guard = 0;
        while (sq.size() > 0 && guard < 2 * DEPTH) begin
            guard++;
            s_step(1'b0, 1'b1, '0);
            n_total++;
            if (s_valid !== 1'b1 || s_dout !== s_exp_dout)
                $display("FAIL drain_%0d: got valid %b dout %h expected 1 %h", guard, s_valid, s_dout, s_exp_dout);
            else n_pass++;
        end
        n_total++;
        if (s_empty !== 1'b1 || s_data_count !== '0 || s_prog_empty !== 1'b1 || s_exp_dout !== 32'h400)
            $display("FAIL drain_end: got empty %b count %0d last %h expected 1 0 00000400",
                     s_empty, s_data_count, s_exp_dout);
        else n_pass++;
        s_step(1'b0, 1'b0, '0);
        n_total++;
        if (s_valid !== 1'b0 || s_dout !== 32'h400)
            $display("FAIL valid_pulse: got valid %b dout %h expected 0 00000400", s_valid, s_dout);
        else n_pass++;
        s_step(1'b0, 1'b1, '0);
        n_total++;
        if (s_underflow !== 1'b1 || s_valid !== 1'b0)
            $display("FAIL underflow_pulse: got udf %b valid %b expected 1 0", s_underflow, s_valid);
        else n_pass++;
        s_step(1'b0, 1'b0, '0);
        n_total++;
        if (s_underflow !== 1'b0)
            $display("FAIL underflow_one_cycle: got %b expected 0", s_underflow);
        else n_pass++;
    endtask

    task automatic test_empty_simul();
        logic [DW-1:0] d;
        d = $urandom;
        s_step(1'b1, 1'b1, d);
        n_total++;
        if ({s_underflow, s_valid, s_empty} !== 3'b100 || s_data_count !== 11'd1)
            $display("FAIL empty_simul: got udf %b valid %b empty %b count %0d expected 1 0 0 1",
                     s_underflow, s_valid, s_empty, s_data_count);
        else n_pass++;
        s_step(1'b0, 1'b1, '0);
        n_total++;
        if (s_valid !== 1'b1 || s_dout !== d || s_empty !== 1'b1)
            $display("FAIL empty_simul_read: got valid %b dout %h empty %b expected 1 %h 1", s_valid, s_dout, s_empty, d);
        else n_pass++;
    endtask

    task automatic test_random_std();
        logic [AW:0] ec;
        int          pw;
        for (int i = 0; i < 3000; i++) begin
            pw = (i < 1500) ? 75 : 25;
            s_step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), $urandom);
            ec = (AW+1)'(sq.size());
            n_total++;
            if ({s_data_count, s_full, s_empty, s_prog_full, s_prog_empty, s_valid, s_overflow, s_underflow} !==
                {ec, ec == DEPTH, ec == 0, ec >= PF, ec <= PE, s_exp_valid, s_exp_ovf, s_exp_udf} ||
                s_dout !== s_exp_dout)
                $display("FAIL random_std_%0d: got count %0d dout %h valid %b expected count %0d dout %h valid %b",
                         i, s_data_count, s_dout, s_valid, ec, s_exp_dout, s_exp_valid);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int            guard;
        logic [DW-1:0] d;
        while (sq.size() < 500) s_step(1'b1, 1'b0, $urandom);
        while (sq.size() > 500) s_step(1'b0, 1'b1, '0);
        n_total++;
        if (s_data_count !== 11'd500)
            $display("FAIL mid_pre_count: got %0d expected 500", s_data_count);
        else n_pass++;
        rst = 1'b1; s_wr_en = 1'b1; s_rd_en = 1'b1; s_din = 32'hBAD0BAD0;
        @(posedge clk); #1;
        rst = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        n_total++;
        if ({s_full, s_empty, s_prog_empty, s_prog_full, s_valid, s_overflow, s_underflow, s_rst_busy} !== 8'b1110_0001 ||
            s_data_count !== '0 || s_dout !== '0)
            $display("FAIL mid_reset_flags: got %b count %0d dout %h expected 11100001 0 0",
                     {s_full, s_empty, s_prog_empty, s_prog_full, s_valid, s_overflow, s_underflow, s_rst_busy},
                     s_data_count, s_dout);
        else n_pass++;
        guard = 0;
        while (s_rst_busy === 1'b1 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        n_total++;
        if (s_rst_busy !== 1'b0 || s_data_count !== '0 || s_empty !== 1'b1 || s_full !== 1'b0)
            $display("FAIL mid_after_busy: got busy %b count %0d empty %b full %b expected 0 0 1 0",
                     s_rst_busy, s_data_count, s_empty, s_full);
        else n_pass++;
        sq.delete(); s_exp_dout = '0;
        fq.delete(); fe.delete(); f_exp_empty = 1'b1;
        d = $urandom;
        s_step(1'b1, 1'b0, d);
        s_step(1'b0, 1'b1, '0);
        n_total++;
        if (s_dout !== d || s_valid !== 1'b1 || s_data_count !== '0)
            $display("FAIL mid_fresh_word: got dout %h valid %b count %0d expected %h 1 0", s_dout, s_valid, s_data_count, d);
        else n_pass++;
    endtask

    task automatic test_fwft_latency();
        f_step(1'b1, 1'b0, 32'hA5A5A5A5);
        n_total++;
        if (f_empty !== 1'b1 || f_data_count !== 11'd1)
            $display("FAIL fwft_edge_k: got empty %b count %0d expected 1 1", f_empty, f_data_count);
        else n_pass++;
        f_step(1'b0, 1'b0, '0);
        n_total++;
        if (f_empty !== 1'b0 || f_valid !== 1'b1 || f_dout !== 32'hA5A5A5A5)
            $display("FAIL fwft_edge_k1: got empty %b valid %b dout %h expected 0 1 a5a5a5a5", f_empty, f_valid, f_dout);
        else n_pass++;
        f_step(1'b0, 1'b1, '0);
        n_total++;
        if (f_empty !== 1'b1 || f_valid !== 1'b0 || f_data_count !== '0)
            $display("FAIL fwft_pop: got empty %b valid %b count %0d expected 1 0 0", f_empty, f_valid, f_data_count);
        else n_pass++;
        f_step(1'b0, 1'b1, '0);
        n_total++;
        if (f_underflow !== 1'b1)
            $display("FAIL fwft_underflow: got %b expected 1", f_underflow);
        else n_pass++;
    endtask

    task automatic test_fwft_stream();
        for (int i = 0; i < 16; i++) f_step(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 5000; i++) begin
            f_step(1'b1, 1'b1, $urandom);
            n_total++;
            if ({f_empty, f_valid, f_overflow, f_underflow} !== {f_exp_empty, !f_exp_empty, f_exp_ovf, f_exp_udf} ||
                f_data_count !== 11'd16 || f_dout !== fq[0])
                $display("FAIL fwft_stream_%0d: got empty %b count %0d dout %h expected %b 16 %h",
                         i, f_empty, f_data_count, f_dout, f_exp_empty, fq[0]);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (f_empty !== 1'b0 || f_dout !== fq[0])
                $display("FAIL fwft_drain_%0d: got empty %b dout %h expected 0 %h", i, f_empty, f_dout, fq[0]);
            else n_pass++;
            f_step(1'b0, 1'b1, '0);
        end
        n_total++;
        if (f_empty !== 1'b1 || f_data_count !== '0)
            $display("FAIL fwft_drain_end: got empty %b count %0d expected 1 0", f_empty, f_data_count);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        s_din = '0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        f_din = '0; f_wr_en = 1'b0; f_rd_en = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_full_simul();
        test_drain();
        test_empty_simul();
        test_random_std();
        test_reset_mid();
        test_fwft_latency();
        test_fwft_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
